// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART constants, receiver state encoding and baud divider helper
package uart_rx_pkg;
  localparam int UART_BITS = 8;
  localparam int UART_SAMPLES = 16;
  localparam int UART_BAUD_RATE = 19200;
  localparam int CLK_FREQ = 50_000_000;
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_BREAK
  } rx_state_e;
  function automatic int baud_div(input int clk_freq, input int baud, input int samples);
    int d;
    d = clk_freq / (baud * samples);
    return d < 1 ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_rx_tick.sv
// baud_tick_gen: free-running divider giving a one-clk tick every DIV clocks
module baud_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign o_tick = cnt_q == LAST;
  assign cnt_d = o_tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver with framing-error detection; define UART_RX_PARITY_EN for 8E1 with o_parity_err
module uart_rx #(
  parameter int UART_BITS = uart_rx_pkg::UART_BITS,
  parameter int CLK_FREQ = uart_rx_pkg::CLK_FREQ,
  parameter int BAUD_RATE = uart_rx_pkg::UART_BAUD_RATE,
  parameter int SAMPLES = uart_rx_pkg::UART_SAMPLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic [UART_BITS-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 o_parity_err,
`endif
  output logic                 o_busy
);
  import uart_rx_pkg::*;
  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, SAMPLES);
  localparam int SC_W = SAMPLES > 1 ? $clog2(SAMPLES) : 1;
  localparam int BC_W = UART_BITS > 1 ? $clog2(UART_BITS) : 1;
  localparam logic [SC_W-1:0] SC_MID = SC_W'(SAMPLES / 2 - 1);
  localparam logic [SC_W-1:0] SC_END = SC_W'(SAMPLES - 1);
  localparam logic [BC_W-1:0] BC_END = BC_W'(UART_BITS - 1);
  rx_state_e state_q, state_d;
  logic tick, at_end, sync_q, rxs_q;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [UART_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic done_q, done_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
`endif
  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .o_tick(tick)
  );
  assign at_end = tick && sc_q == SC_END;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 1'b1;
      rxs_q <= 1'b1;
      state_q <= RX_IDLE;
      sc_q <= '0;
      bc_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      sync_q <= i_rx;
      rxs_q <= sync_q;
      state_q <= state_d;
      sc_q <= sc_d;
      bc_q <= bc_d;
      sh_q <= sh_d;
      data_q <= data_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q <= par_d;
      perr_q <= perr_d;
`endif
    end
  end
  // sc free-runs on ticks in the timed states; IDLE and BREAK hold it at zero
  always_comb begin
    state_d = state_q;
    sc_d = tick ? (sc_q == SC_END ? '0 : sc_q + 1'b1) : sc_q;
    bc_d = bc_q;
    sh_d = sh_q;
    data_d = data_q;
    done_d = 1'b0;
    ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
    perr_d = 1'b0;
`endif
    case (state_q)
      RX_IDLE: begin
        sc_d = '0;
        state_d = rxs_q ? RX_IDLE : RX_START;
      end
      RX_START: if (tick && sc_q == SC_MID) begin
        state_d = rxs_q ? RX_IDLE : RX_DATA;
        sc_d = '0;
        bc_d = '0;
      end
      RX_DATA: if (at_end) begin
        sh_d = {rxs_q, sh_q[UART_BITS-1:1]};
        bc_d = bc_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bc_q == BC_END) state_d = RX_PARITY;
`else
        if (bc_q == BC_END) state_d = RX_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: if (at_end) begin
        par_d = rxs_q ^ (^sh_q);
        state_d = RX_STOP;
      end
`endif
      RX_STOP: if (at_end) begin
        state_d = rxs_q ? RX_IDLE : RX_BREAK;
        ferr_d = !rxs_q;
`ifdef UART_RX_PARITY_EN
        perr_d = rxs_q && par_q;
        done_d = rxs_q && !par_q;
        data_d = rxs_q && !par_q ? sh_q : data_q;
`else
        done_d = rxs_q;
        data_d = rxs_q ? sh_q : data_q;
`endif
      end
      RX_BREAK: begin
        sc_d = '0;
        state_d = rxs_q ? RX_IDLE : RX_BREAK;
      end
      default: state_d = RX_IDLE;
    endcase
  end
  assign o_rx_data = data_q;
  assign o_rx_done = done_q;
  assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif
  assign o_busy = state_q != RX_IDLE;
endmodule
